regfile_wb_scheduler: RTL and testbench

- Write-back scheduler for the 32x32 register file.
- Shares the single write port (wa/wda/reg_wr) between the single-cycle ALU result path and the variable-latency load path.
- Buffers load returns in a small FIFO and keeps a per-register pending-load scoreboard.
- Raises a decode stall on RAW/WAW hazards against loads still in flight.

---
 rtl/regfile_wb_scheduler.sv | 125 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the single register-file write port between
// the ALU path and a load-return FIFO, tracks pending loads and stalls decode.
module regfile_wb_scheduler #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_issue,
  input  logic [4:0]  lsu_issue_rd,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        dec_valid,
  input  logic [4:0]  dec_ra,
  input  logic [4:0]  dec_rb,
  input  logic [4:0]  dec_rd,
  output logic        stall,
  output logic [4:0]  wa,
  output logic [31:0] wda,
  output logic        reg_wr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve_cnt;
  logic [31:1]   busy;
  logic          src_lsu;

  logic          fifo_nonempty;
  logic          force_head;
  logic          alu_grant;
  logic          pop;
  logic          push;
  logic [31:0]   busy_full;
  logic [31:0]   busy_nxt;

  always_comb begin
    fifo_nonempty = (count != '0);
    force_head    = (starve_cnt == SW'(STARVE_LIMIT)) && fifo_nonempty;
    alu_ready     = !force_head;
    lsu_ready     = (count < (AW+1)'(DEPTH));
    alu_grant     = alu_valid && !force_head;
    pop           = !alu_grant && fifo_nonempty;
    push          = lsu_valid && lsu_ready;
  end

  // Bit 0 of the full vector is tied low so x0 never reports busy.
  always_comb begin
    busy_full = {busy, 1'b0};
    stall     = dec_valid && (busy_full[dec_ra] || busy_full[dec_rb] || busy_full[dec_rd]);
  end

  // Clear from the committing load write first, then set, so set wins.
  always_comb begin
    busy_nxt = {busy, 1'b0};
    if (reg_wr && src_lsu)
      busy_nxt[wa] = 1'b0;
    if (lsu_issue && (lsu_issue_rd != '0))
      busy_nxt[lsu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      src_lsu    <= 1'b0;
      reg_wr     <= 1'b0;
      wa         <= '0;
      wda        <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      if (!fifo_nonempty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      busy <= busy_nxt[31:1];

      reg_wr <= 1'b0;
      if (alu_grant) begin
        src_lsu <= 1'b0;
        if (alu_rd != '0) begin
          reg_wr <= 1'b1;
          wa     <= alu_rd;
          wda    <= alu_data;
        end
      end else if (pop) begin
        src_lsu <= 1'b1;
        if (fifo_rd[rd_ptr] != '0) begin
          reg_wr <= 1'b1;
          wa     <= fifo_rd[rd_ptr];
          wda    <= fifo_data[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic,
// all checked against a queue-based behavioural model of the write-back rules.
module tb_regfile_wb_scheduler;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        dec_valid;
  logic [4:0]  dec_ra;
  logic [4:0]  dec_rb;
  logic [4:0]  dec_rd;
  logic        stall;
  logic [4:0]  wa;
  logic [31:0] wda;
  logic        reg_wr;

  regfile_wb_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_rd(dec_rd),
    .stall(stall), .wa(wa), .wda(wda), .reg_wr(reg_wr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  int          checks = 0;
  int          errors = 0;
  entry_t      q[$];
  bit          m_busy [32];
  int          m_starve;
  bit          m_wr;
  bit          m_from_load;
  logic [4:0]  m_wa;
  logic [31:0] m_wda;
  bit          model_live = 0;
  int          ready_lows = 0;
  bit          s_alu_ready;
  bit          s_lsu_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit     force_now, popped, accept;
    entry_t e;
    int     had;
    if (!reset) begin
      q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_starve = 0;
      m_wr = 0; m_from_load = 0; m_wa = '0; m_wda = '0;
    end else begin
      had       = q.size();
      force_now = (m_starve == STARVE_LIMIT) && had > 0;
      accept    = lsu_valid && (had < DEPTH);
      if (m_wr && m_from_load) m_busy[m_wa] = 0;
      if (lsu_issue && lsu_issue_rd != 0) m_busy[lsu_issue_rd] = 1;
      popped = 0;
      m_wr   = 0;
      if (alu_valid && !force_now) begin
        m_from_load = 0;
        if (alu_rd != 0) begin m_wr = 1; m_wa = alu_rd; m_wda = alu_data; end
      end else if (had > 0) begin
        e = q.pop_front();
        popped = 1;
        m_from_load = 1;
        if (e.rd != 0) begin m_wr = 1; m_wa = e.rd; m_wda = e.data; end
      end
      if (accept) begin
        e.rd = lsu_rd; e.data = lsu_data;
        q.push_back(e);
      end
      if (had == 0 || popped) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
    end
    model_live = 1;
  endtask

  task automatic cycle();
    bit exp_stall;
    @(negedge clock);
    s_alu_ready = alu_ready;
    s_lsu_ready = lsu_ready;
    if (!alu_ready) ready_lows++;
    if (model_live) begin
      exp_stall = dec_valid && ((dec_ra != 0 && m_busy[dec_ra]) ||
                                (dec_rb != 0 && m_busy[dec_rb]) ||
                                (dec_rd != 0 && m_busy[dec_rd]));
      check("alu_ready", alu_ready, !((m_starve == STARVE_LIMIT) && q.size() > 0));
      check("lsu_ready", lsu_ready, q.size() < DEPTH);
      check("stall", stall, exp_stall);
    end
    @(posedge clock);
    model_step();
    #1;
    check("reg_wr", reg_wr, m_wr);
    if (m_wr) begin
      check("wa", wa, m_wa);
      check("wda", wda, m_wda);
    end
    check("x0_write", reg_wr && (wa == 0), 0);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_issue = 0; lsu_issue_rd = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    dec_valid = 0; dec_ra = '0; dec_rb = '0; dec_rd = '0;
  endtask

  initial begin
    int lows0, accepted, budget;
    #1;
    idle_inputs();

    // Reset with an ALU request pending, then first write after release.
    reset = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
    repeat (2) cycle();
    reset = 1;
    cycle();
    check("first_wr", reg_wr, 1);
    check("first_wa", wa, 5);
    check("first_wda", wda, 32'hDEAD_BEEF);
    alu_valid = 0;
    cycle();

    // Load hazard on r7.
    lsu_issue = 1; lsu_issue_rd = 7;
    cycle();
    lsu_issue = 0; dec_valid = 1; dec_ra = 7;
    cycle();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    cycle();
    lsu_valid = 0;
    repeat (4) cycle();
    dec_valid = 0; dec_ra = 0;

    // Contention: the queued load is forced through once in 7 cycles.
    lows0 = ready_lows;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0A0_0001;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h55;
    cycle();
    lsu_valid = 0;
    for (int i = 0; i < 6; i++) begin
      alu_data = 32'hA0A0_0010 + i;
      cycle();
    end
    check("starve_force_count", ready_lows - lows0, 1);
    alu_valid = 0;
    repeat (2) cycle();

    // FIFO full: three returns back to back, the third held until space frees.
    alu_valid = 1; alu_rd = 12; alu_data = 32'hC0DE;
    accepted = 0; budget = 40;
    while (accepted < 3 && budget > 0) begin
      lsu_valid = 1; lsu_rd = 5'(13 + accepted); lsu_data = 32'hF000 + accepted;
      cycle();
      if (s_lsu_ready) accepted++;
      budget--;
    end
    check("fifo_full_accepted", accepted, 3);
    lsu_valid = 0; alu_valid = 0;
    repeat (4) cycle();

    // x0 never writes and never stalls.
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1111;
    lsu_issue = 1; lsu_issue_rd = 0;
    dec_valid = 1; dec_ra = 0; dec_rb = 0; dec_rd = 0;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h2222;
    cycle();
    lsu_valid = 0; lsu_issue = 0; alu_valid = 0;
    repeat (3) cycle();
    check("x0_stall", stall, 0);
    idle_inputs();

    // Reset while loads are queued and r3 is busy.
    alu_valid = 1; alu_rd = 20; alu_data = 32'h77;
    lsu_issue = 1; lsu_issue_rd = 3;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
    cycle();
    lsu_issue = 0; lsu_rd = 4; lsu_data = 32'h44;
    cycle();
    lsu_valid = 0; alu_valid = 0;
    reset = 0;
    cycle();
    reset = 1; dec_valid = 1; dec_ra = 3;
    repeat (4) cycle();
    idle_inputs();

    // Random traffic; requests are held while not accepted.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      if (!(alu_valid && !s_alu_ready)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(lsu_valid && !s_lsu_ready)) begin
        lsu_valid = ($urandom_range(0, 1) != 0);
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      lsu_issue    = ($urandom_range(0, 2) == 0);
      lsu_issue_rd = 5'($urandom_range(0, 7));
      dec_valid    = ($urandom_range(0, 1) != 0);
      dec_ra       = 5'($urandom_range(0, 7));
      dec_rb       = 5'($urandom_range(0, 7));
      dec_rd       = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
